// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: anode one-hots,
// the hex segment table and the scan FSM state type.
package seg_scan_pkg;

  localparam logic [3:0] AN0    = 4'b1110;
  localparam logic [3:0] AN1    = 4'b1101;
  localparam logic [3:0] AN2    = 4'b1011;
  localparam logic [3:0] AN3    = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low g..a patterns, entry 15 first so SEG_TABLE[n] is digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [0:0] {StBlank, StShow} scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex to active-low 7-segment (g..a) decoder.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed display scanner: each slot blanks the anodes first so the
// external mux can settle, then shows the registered segment pattern.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 16
) (
  input  logic       myCLK,
  input  logic       Reset,
  input  logic       freeze,
  input  logic [3:0] store,
  input  logic [3:0] dp,
  output logic [3:0] AN_sel,
  output logic [3:0] AN,
  output logic [7:0] SEG
);

  localparam logic [19:0] CntLast   = 20'(DIV - 1);
  localparam logic [19:0] BlankLast = 20'(BLANK - 1);

  scan_state_e state_q, state_d;
  logic [19:0] slotCnt_q, slotCnt_d;
  logic [3:0]  anSel_d, an_d;
  logic [7:0]  seg_d;
  logic [6:0]  segDecoded;
  logic        dpBit;

  seg7_decode u_decode (
    .hex (store),
    .seg (segDecoded)
  );

  always_comb begin
    unique case (AN_sel)
      AN1:     dpBit = dp[1];
      AN2:     dpBit = dp[2];
      AN3:     dpBit = dp[3];
      default: dpBit = dp[0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    slotCnt_d = (slotCnt_q == CntLast) ? 20'd0 : slotCnt_q + 20'd1;
    anSel_d   = AN_sel;
    an_d      = AN;
    seg_d     = SEG;
    unique case (state_q)
      StBlank: begin
        if (slotCnt_q == BlankLast) begin
          state_d = StShow;
          an_d    = AN_sel;
          seg_d   = {~dpBit, segDecoded};
        end
      end
      StShow: begin
        if (slotCnt_q == CntLast) begin
          state_d = StBlank;
          an_d    = AN_OFF;
          // Digit select moves only as the anodes go dark, so the mux has the
          // whole blank window to return the new nibble.
          if (!freeze) anSel_d = {AN_sel[2:0], AN_sel[3]};
        end
      end
      default: state_d = StBlank;
    endcase
  end

  always_ff @(posedge myCLK) begin
    if (Reset) begin
      state_q   <= StBlank;
      slotCnt_q <= 20'd0;
      AN_sel    <= AN0;
      AN        <= AN_OFF;
      SEG       <= 8'hFF;
    end else begin
      state_q   <= state_d;
      slotCnt_q <= slotCnt_d;
      AN_sel    <= anSel_d;
      AN        <= an_d;
      SEG       <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with DIV=8, BLANK=2 and a 1-clock registered mux model.
module tb_seg_scan;

  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;

  logic       myCLK  = 1'b0;
  logic       Reset  = 1'b1;
  logic       freeze = 1'b0;
  logic [3:0] store  = 4'h0;
  logic [3:0] dp     = 4'h0;
  logic [3:0] AN_sel, AN;
  logic [7:0] SEG;

  int nCmp = 0;
  int nBad = 0;
  bit chkEn = 1'b0;

  int         mode     = 0;
  logic [3:0] fixedVal = 4'h0;
  logic [3:0] digVal [4];

  logic [6:0] refTbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] seq30 [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

  typedef struct {
    logic [3:0] val;
    logic [3:0] dpv;
    logic [7:0] seg;
  } vec_t;
  vec_t vecs [16];

  seg_scan #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .myCLK  (myCLK),
    .Reset  (Reset),
    .freeze (freeze),
    .store  (store),
    .dp     (dp),
    .AN_sel (AN_sel),
    .AN     (AN),
    .SEG    (SEG)
  );

  always #5 myCLK = ~myCLK;

  function automatic logic [3:0] oneHotLow(int d);
    logic [3:0] v;
    v = 4'hF;
    v[d] = 1'b0;
    return v;
  endfunction

  function automatic int selIdx(logic [3:0] s);
    for (int i = 0; i < 4; i++) if (!s[i]) return i;
    return 0;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Display mux: returns the nibble for AN_sel one clock later.
  always @(posedge myCLK) begin
    case (mode)
      0:       store <= fixedVal;
      1:       store <= digVal[selIdx(AN_sel)];
      2:       store <= (store == 4'h0) ? 4'hF : 4'h0;
      default: store <= 4'($urandom);
    endcase
  end

  // Reference: slot position, current digit and the pattern latched at show start.
  int         mCnt = 0;
  int         mDig = 0;
  logic [7:0] mSeg = 8'hFF;
  int         rc, rd;

  always @(posedge myCLK) begin
    if (Reset) begin
      mCnt <= 0;
      mDig <= 0;
      mSeg <= 8'hFF;
    end else begin
      rc = (mCnt + 1) % DIV;
      rd = mDig;
      if (rc == 0 && !freeze) rd = (rd + 1) % 4;
      mCnt <= rc;
      mDig <= rd;
      if (rc == BLANK) mSeg <= {~dp[rd], refTbl[store]};
    end
  end

  always @(negedge myCLK) begin
    if (chkEn) begin
      check("model_an", {4'h0, AN}, {4'h0, (mCnt >= BLANK) ? oneHotLow(mDig) : 4'hF});
      check("model_an_sel", {4'h0, AN_sel}, {4'h0, oneHotLow(mDig)});
      check("model_seg", SEG, mSeg);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge myCLK);
  endtask

  // Leaves the bench at the negedge with slot count 0, reset just released.
  task automatic doReset();
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] held;
    int         dig;

    vecs[0]  = '{4'h0, 4'b1110, 8'hC0};
    vecs[1]  = '{4'h1, 4'b0001, 8'h79};
    vecs[2]  = '{4'h2, 4'b1110, 8'hA4};
    vecs[3]  = '{4'h3, 4'b0001, 8'h30};
    vecs[4]  = '{4'h4, 4'b1110, 8'h99};
    vecs[5]  = '{4'h5, 4'b0001, 8'h12};
    vecs[6]  = '{4'h6, 4'b1110, 8'h82};
    vecs[7]  = '{4'h7, 4'b0001, 8'h78};
    vecs[8]  = '{4'h8, 4'b1110, 8'h80};
    vecs[9]  = '{4'h9, 4'b0001, 8'h10};
    vecs[10] = '{4'hA, 4'b1110, 8'h88};
    vecs[11] = '{4'hB, 4'b0001, 8'h03};
    vecs[12] = '{4'hC, 4'b1110, 8'hC6};
    vecs[13] = '{4'hD, 4'b0001, 8'h21};
    vecs[14] = '{4'hE, 4'b1110, 8'h86};
    vecs[15] = '{4'hF, 4'b0001, 8'h0E};
    digVal = '{4'd1, 4'd2, 4'd3, 4'd4};

    Reset = 1'b1;
    cyc(3);
    chkEn = 1'b1;
    check("reset_an", {4'h0, AN}, 8'h0F);
    check("reset_seg", SEG, 8'hFF);
    check("reset_an_sel", {4'h0, AN_sel}, 8'h0E);

    // Decode table on digit 0; only dp[0] may reach SEG[7].
    mode = 0;
    for (int i = 0; i < 16; i++) begin
      fixedVal = vecs[i].val;
      dp       = vecs[i].dpv;
      doReset();
      cyc(2);
      check("decode_seg", SEG, vecs[i].seg);
      check("decode_an", {4'h0, AN}, 8'h0E);
    end

    // First slot after release: 2 blank clocks, 6 shown, then blank on digit 1.
    fixedVal = 4'h5;
    dp       = 4'h0;
    doReset();
    check("r29_blank0", {4'h0, AN}, 8'h0F);
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      if (k < 2 || k == 8) begin
        check("r29_blank", {4'h0, AN}, 8'h0F);
      end else begin
        check("r29_an", {4'h0, AN}, 8'h0E);
        check("r29_seg", SEG, 8'h92);
      end
    end
    check("r29_an_sel", {4'h0, AN_sel}, 8'h0D);

    // Full ring with mux digits 1..4.
    mode = 1;
    doReset();
    for (int k = 1; k <= 32; k++) begin
      cyc(1);
      if (k % 8 == 4 && k < 32) begin
        check("r30_an", {4'h0, AN}, {4'h0, oneHotLow(k / 8)});
        check("r30_seg", SEG, seq30[k / 8]);
      end
    end
    check("r30_wrap_an_sel", {4'h0, AN_sel}, 8'h0E);
    check("r30_wrap_an", {4'h0, AN}, 8'h0F);

    // Decimal point only on digit 2.
    mode     = 0;
    fixedVal = 4'h8;
    dp       = 4'b0100;
    doReset();
    for (int k = 1; k < 32; k++) begin
      cyc(1);
      if (k % 8 >= 2) begin
        dig = (k / 8) % 4;
        check("r31_an", {4'h0, AN}, {4'h0, oneHotLow(dig)});
        check("r31_seg", SEG, (dig == 2) ? 8'h00 : 8'h80);
      end
    end

    // Freeze on digit 1 across two wraps.
    fixedVal = 4'h3;
    dp       = 4'h0;
    doReset();
    cyc(9);
    freeze = 1'b1;
    for (int k = 10; k <= 25; k++) begin
      cyc(1);
      check("r32_an_sel", {4'h0, AN_sel}, 8'h0D);
      check("r32_an", {4'h0, AN}, (k % 8 < 2) ? 8'h0F : 8'h0D);
    end
    freeze = 1'b0;
    cyc(6);
    check("r32_hold_an_sel", {4'h0, AN_sel}, 8'h0D);
    cyc(1);
    check("r32_next_an_sel", {4'h0, AN_sel}, 8'h0B);

    // store toggling during SHOW must not disturb SEG; then reset mid-SHOW.
    mode = 2;
    doReset();
    cyc(1);
    held = store;
    for (int k = 2; k <= 7; k++) begin
      cyc(1);
      check("r33_hold", SEG, {1'b1, refTbl[held]});
    end
    cyc(5);
    Reset = 1'b1;
    cyc(1);
    check("r33_rst_an", {4'h0, AN}, 8'h0F);
    check("r33_rst_seg", SEG, 8'hFF);
    check("r33_rst_an_sel", {4'h0, AN_sel}, 8'h0E);
    Reset = 1'b0;

    // Random store, dp, freeze and occasional reset against the reference.
    mode = 3;
    for (int i = 0; i < 1500; i++) begin
      cyc(1);
      freeze = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
      Reset = ($urandom_range(0, 199) == 0);
    end
    Reset = 1'b0;
    freeze = 1'b0;
    cyc(2);
    chkEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
